dmem_store_buffer: RTL and testbench

- FIFO store buffer between the OOO core's data-memory ports and the data memory.
- Accepts committed stores from the core and drains them in order to the memory write port, one store per cycle.
- Serves core loads with 1-cycle latency, forwarding the youngest matching buffered store data in place of memory data.
- Decouples store commit from memory write availability; load-after-store ordering is preserved by forwarding.

---
 rtl/dmem_store_buffer_pkg.sv | 13 +
 rtl/dmem_store_buffer_fwd_match.sv | 32 +++
 rtl/dmem_store_buffer.sv | 85 ++++++++
 tb/tb_dmem_store_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_store_buffer_pkg.sv
// dmem_store_buffer_pkg: shared entry type and sizing constants for the data-memory store buffer
package dmem_store_buffer_pkg;
    localparam int SB_DEPTH  = 8;
    localparam int SB_ADDR_W = 64;
    localparam int SB_DATA_W = 64;
    localparam int SB_PTR_W  = $clog2(SB_DEPTH);
    localparam int SB_CNT_W  = SB_PTR_W + 1;
    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/dmem_store_buffer_fwd_match.sv
// sb_fwd_match: youngest-first doubleword address match over the occupied store buffer entries
module sb_fwd_match
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  sb_entry_t         entries [DEPTH],
    input  logic [PTR_W-1:0]  head,
    input  logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);
    logic [PTR_W-1:0] idx;
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (i < int'(count) && entries[idx].valid &&
                entries[idx].addr[ADDR_W-1:3] == ld_addr[ADDR_W-1:3]) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: in-order store FIFO draining to memory, with 1-cycle load forwarding
module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    output logic [DATA_W-1:0] ld_data_o,
    output logic              ld_data_valid_o,
    output logic              ld_fwd_o,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    input  logic              mem_wr_stall_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o
);
    sb_entry_t         entries [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic              push, drain, hit, ld_valid_q, fwd_hit_q;
    logic [DATA_W-1:0] hit_data, fwd_data_q;

    assign empty_o         = count == '0;
    assign count_o         = count;
    assign mem_wr_en_o     = !empty_o;
    assign mem_wr_addr_o   = entries[head].addr;
    assign mem_wr_data_o   = entries[head].data;
    assign drain           = mem_wr_en_o && !mem_wr_stall_i;
    assign st_ready_o      = count < CNT_W'(DEPTH) || drain;
    assign push            = st_valid_i && st_ready_o;
    assign mem_rd_en_o     = ld_valid_i;
    assign mem_rd_addr_o   = ld_addr_i;
    assign ld_data_valid_o = ld_valid_q;
    assign ld_fwd_o        = fwd_hit_q;
    assign ld_data_o       = !ld_valid_q ? '0 : fwd_hit_q ? fwd_data_q : mem_rd_data_i;

    sb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match (
        .entries (entries),
        .head    (head),
        .count   (count),
        .ld_addr (ld_addr_i),
        .hit     (hit),
        .data    (hit_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ld_valid_q <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
        end else begin
            if (drain) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            if (push) begin
                entries[tail] <= '{valid: 1'b1, addr: st_addr_i, data: st_data_i};
                tail          <= tail + 1'b1;
            end
            count      <= count + CNT_W'(push) - CNT_W'(drain);
            ld_valid_q <= ld_valid_i;
            fwd_hit_q  <= ld_valid_i && hit;
            fwd_data_q <= hit_data;
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed self-checking bench for the store buffer
module tb_dmem_store_buffer;
    logic        clk = 1'b0, reset = 1'b1;
    logic        st_valid = 1'b0, st_ready;
    logic [63:0] st_addr = '0, st_data = '0;
    logic        ld_valid = 1'b0;
    logic [63:0] ld_addr = '0, ld_data;
    logic        ld_data_valid, ld_fwd;
    logic        mem_wr_en, mem_wr_stall = 1'b0, mem_rd_en;
    logic [63:0] mem_wr_addr, mem_wr_data, mem_rd_addr, mem_rd_data = '0;
    logic [3:0]  count;
    logic        empty;
    int          checks = 0, failures = 0, cyc = 0;
    logic [127:0] wr_q[$], exp_q[$];
    int          wr_c[$];

    dmem_store_buffer dut (
        .clk(clk), .reset(reset),
        .st_valid_i(st_valid), .st_ready_o(st_ready), .st_addr_i(st_addr), .st_data_i(st_data),
        .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_o(ld_data),
        .ld_data_valid_o(ld_data_valid), .ld_fwd_o(ld_fwd),
        .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
        .mem_wr_stall_i(mem_wr_stall),
        .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_data),
        .count_o(count), .empty_o(empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (!reset && mem_wr_en && !mem_wr_stall) begin
            wr_q.push_back({mem_wr_addr, mem_wr_data});
            wr_c.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        step();
        st_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (ld_data_valid !== 1'b0 || ld_fwd !== 1'b0 || ld_data !== 64'h0) begin
            failures++; $display("FAIL reset_ld got=%b/%b/%h exp=0/0/0", ld_data_valid, ld_fwd, ld_data); end
        checks++; if (mem_wr_en !== 1'b0 || st_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ctrl wr_en=%b st_ready=%b exp=0/1", mem_wr_en, st_ready); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        wr_q.delete(); wr_c.delete();
        mem_wr_stall = 1'b0;
        push(64'h10, 64'hAA);
        push(64'h18, 64'hBB);
        step();
        exp_q = '{{64'h10, 64'hAA}, {64'h18, 64'hBB}};
        checks++; if (wr_q.size() != 2) begin failures++; $display("FAIL basic_nwr got=%0d exp=2", wr_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_wr%0d got=%h exp=%h", i, wr_q[i], exp_q[i]); end
        end
        if (wr_c.size() == 2) begin
            checks++; if (wr_c[1] - wr_c[0] != 1) begin failures++; $display("FAIL basic_consec got=%0d exp=1", wr_c[1] - wr_c[0]); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full();
        wr_q.delete(); exp_q.delete();
        mem_wr_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(64'h100 + 64'(8 * i), 64'(i + 1));
            exp_q.push_back({64'h100 + 64'(8 * i), 64'(i + 1)});
        end
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", count); end
        checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", st_ready); end
        st_valid = 1'b1; st_addr = 64'h200; st_data = 64'h99;
        step();
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_ignored got=%0d exp=8", count); end
        mem_wr_stall = 1'b0;
        #1;
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL full_ready_drain got=%b exp=1", st_ready); end
        step();
        st_valid = 1'b0;
        exp_q.push_back({64'h200, 64'h99});
        repeat (10) step();
        checks++; if (wr_q.size() != 9) begin failures++; $display("FAIL full_nwr got=%0d exp=9", wr_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL full_wr%0d got=%h exp=%h", i, wr_q[i], exp_q[i]); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_empty got=%b exp=1", empty); end
    endtask

    task automatic test_fwd();
        wr_q.delete();
        mem_wr_stall = 1'b1;
        push(64'h20, 64'h1);
        push(64'h20, 64'h2);
        ld_valid = 1'b1; ld_addr = 64'h20; mem_rd_data = 64'h5555;
        #1;
        checks++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 64'h20) begin
            failures++; $display("FAIL fwd_rd got=%b/%h exp=1/20", mem_rd_en, mem_rd_addr); end
        step();
        ld_addr = 64'h28;
        checks++; if (ld_data_valid !== 1'b1 || ld_fwd !== 1'b1 || ld_data !== 64'h2) begin
            failures++; $display("FAIL fwd_youngest got=%b/%b/%h exp=1/1/2", ld_data_valid, ld_fwd, ld_data); end
        step();
        ld_addr = 64'h27;
        checks++; if (ld_data_valid !== 1'b1 || ld_fwd !== 1'b0 || ld_data !== 64'h5555) begin
            failures++; $display("FAIL fwd_miss got=%b/%b/%h exp=1/0/5555", ld_data_valid, ld_fwd, ld_data); end
        step();
        ld_valid = 1'b0;
        checks++; if (ld_fwd !== 1'b1 || ld_data !== 64'h2) begin
            failures++; $display("FAIL fwd_lowbits got=%b/%h exp=1/2", ld_fwd, ld_data); end
        step();
        checks++; if (ld_data_valid !== 1'b0) begin failures++; $display("FAIL fwd_idle got=%b exp=0", ld_data_valid); end
        mem_wr_stall = 1'b0;
        repeat (3) step();
        exp_q = '{{64'h20, 64'h1}, {64'h20, 64'h2}};
        checks++; if (wr_q.size() != 2) begin failures++; $display("FAIL fwd_nwr got=%0d exp=2", wr_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL fwd_wr%0d got=%h exp=%h", i, wr_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_same_cycle();
        mem_wr_stall = 1'b1;
        st_valid = 1'b1; st_addr = 64'h30; st_data = 64'h5;
        ld_valid = 1'b1; ld_addr = 64'h30; mem_rd_data = 64'h7777;
        step();
        st_valid = 1'b0;
        checks++; if (ld_data_valid !== 1'b1 || ld_fwd !== 1'b0 || ld_data !== 64'h7777) begin
            failures++; $display("FAIL same_cycle got=%b/%b/%h exp=1/0/7777", ld_data_valid, ld_fwd, ld_data); end
        step();
        checks++; if (ld_fwd !== 1'b1 || ld_data !== 64'h5) begin
            failures++; $display("FAIL next_cycle got=%b/%h exp=1/5", ld_fwd, ld_data); end
        mem_wr_stall = 1'b0;
        #1;
        checks++; if (mem_wr_en !== 1'b1) begin failures++; $display("FAIL drain_en got=%b exp=1", mem_wr_en); end
        step();
        ld_valid = 1'b0;
        checks++; if (ld_fwd !== 1'b1 || ld_data !== 64'h5 || count !== 4'd0) begin
            failures++; $display("FAIL drain_search got=%b/%h/%0d exp=1/5/0", ld_fwd, ld_data, count); end
    endtask

    task automatic test_wrap();
        exp_q.delete();
        mem_wr_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(64'h400 + 64'(8 * i), 64'h1000 + 64'(i));
            exp_q.push_back({64'h400 + 64'(8 * i), 64'h1000 + 64'(i)});
        end
        wr_q.delete();
        mem_wr_stall = 1'b0;
        for (int k = 0; k < 20; k++) begin
            st_valid = 1'b1; st_addr = 64'h500 + 64'(8 * k); st_data = 64'h2000 + 64'(k);
            exp_q.push_back({st_addr, st_data});
            #1;
            checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL wrap_ready%0d got=%b exp=1", k, st_ready); end
            step();
            checks++; if (count !== 4'd8) begin failures++; $display("FAIL wrap_count%0d got=%0d exp=8", k, count); end
        end
        st_valid = 1'b0;
        repeat (10) step();
        checks++; if (wr_q.size() != 28) begin failures++; $display("FAIL wrap_nwr got=%0d exp=28", wr_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_wr%0d got=%h exp=%h", i, wr_q[i], exp_q[i]); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid();
        mem_wr_stall = 1'b1;
        for (int i = 0; i < 5; i++) push(64'h600 + 64'(8 * i), 64'h3000 + 64'(i));
        checks++; if (count !== 4'd5) begin failures++; $display("FAIL rst_mid_fill got=%0d exp=5", count); end
        wr_q.delete();
        ld_valid = 1'b1; ld_addr = 64'h600;
        reset = 1'b1;
        step();
        reset = 1'b0; ld_valid = 1'b0; mem_wr_stall = 1'b0;
        #1;
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin
            failures++; $display("FAIL rst_mid_count got=%0d/%b exp=0/1", count, empty); end
        checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL rst_mid_wr_en got=%b exp=0", mem_wr_en); end
        checks++; if (ld_data_valid !== 1'b0 || ld_fwd !== 1'b0) begin
            failures++; $display("FAIL rst_mid_ld got=%b/%b exp=0/0", ld_data_valid, ld_fwd); end
        repeat (5) step();
        checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL rst_mid_nwr got=%0d exp=0", wr_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_fwd();
        test_same_cycle();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
